// File: rtl/linear_pkg.sv
// Shared types, constants and helpers for the parameterised INT8 linear engine.
package linear_pkg;
    localparam int ELEM_W = 8;

    localparam logic OUT_INT32 = 1'b0;
    localparam logic OUT_INT8  = 1'b1;
    localparam int   OW_INT32  = 32;
    localparam int   OW_INT8   = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_POST, S_WRITE, S_DONE
    } state_t;

    typedef struct packed {
        logic       out_int8;
        logic       relu;
        logic [4:0] shift;
    } cfg_t;

    function automatic logic [7:0] sat8(input logic signed [63:0] v);
        if (v > 64'sd127)
            return 8'h7f;
        else if (v < -64'sd128)
            return 8'h80;
        else
            return v[7:0];
    endfunction
endpackage

// File: rtl/linear_dot.sv
// LANES-wide signed INT8 dot product with a single output register.
module linear_dot
    import linear_pkg::*;
#(
    parameter int LANES = 8,
    parameter int ACC_W = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [LANES-1:0][ELEM_W-1:0]    x_word,
    input  logic [LANES-1:0][ELEM_W-1:0]    w_word,
    output logic signed [ACC_W-1:0]         dot
);
    logic signed [2*ELEM_W-1:0] prod [LANES];
    logic signed [ACC_W-1:0]    sum;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign prod[i] = $signed(x_word[i]) * $signed(w_word[i]);
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++)
            sum = sum + ACC_W'(prod[i]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            dot <= '0;
        else
            dot <= sum;
    end
endmodule

// File: rtl/linear_param.sv
// Y = X*W engine: streams X rows and W^T rows word by word, post-processes each
// accumulator (ReLU, shift, optional INT8 saturation) and packs results into Y words.
module linear_param
    import linear_pkg::*;
#(
    parameter int M      = 16,
    parameter int K      = 64,
    parameter int N      = 64,
    parameter int DATA_W = 64,
    parameter int LANES  = DATA_W / 8,
    parameter int ACC_W  = 32,
    parameter int X_BASE = 0,
    parameter int W_BASE = 0,
    parameter int Y_BASE = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cfg_out_int8,
    input  logic              cfg_relu,
    input  logic [4:0]        cfg_shift,
    output logic              busy,
    output logic              done,
    output logic              write_en_bar0,
    output logic [DATA_W-1:0] data_in_bar0,
    output logic [31:0]       addr_bar0,
    input  logic [DATA_W-1:0] data_out_bar0,
    output logic              write_en_bar1,
    output logic [DATA_W-1:0] data_in_bar1,
    output logic [31:0]       addr_bar1,
    input  logic [DATA_W-1:0] data_out_bar1
);
    localparam int KW     = K / LANES;
    localparam int PACK32 = DATA_W / OW_INT32;
    localparam int PACK8  = DATA_W / OW_INT8;
    localparam int STAGES = 1;

    state_t                  state;
    cfg_t                    cfg;
    logic [31:0]             m, n, kw, elem, wr_word;
    logic                    wait_cnt, last_elem;
    logic signed [ACC_W-1:0] acc, dot;
    logic [DATA_W-1:0]       pack_buf;
    logic [STAGES:0]         vld_pipe;

    logic signed [ACC_W-1:0] r_relu, r_shift;
    logic [7:0]              r8;
    logic [31:0]             slot;
    logic                    last_slot, is_last;

    linear_dot #(.LANES(LANES), .ACC_W(ACC_W)) u_dot (
        .clk    (clk),
        .rst    (rst),
        .x_word (data_out_bar0),
        .w_word (data_out_bar1),
        .dot    (dot)
    );

    always_comb begin
        r_relu    = (cfg.relu && acc[ACC_W-1]) ? '0 : acc;
        r_shift   = r_relu >>> cfg.shift;
        r8        = sat8(64'(r_shift));
        slot      = (cfg.out_int8 == OUT_INT8) ? (elem % PACK8) : (elem % PACK32);
        last_slot = (cfg.out_int8 == OUT_INT8) ? (slot == PACK8 - 1) : (slot == PACK32 - 1);
        is_last   = (m == M - 1) && (n == N - 1);
    end

    // bar1 is shared: W reads only in ISSUE, Y writes only in WRITE.
    assign addr_bar0     = (state == S_ISSUE) ? 32'(X_BASE + m * KW + kw) : '0;
    assign addr_bar1     = (state == S_WRITE) ? 32'(Y_BASE + wr_word) :
                           (state == S_ISSUE) ? 32'(W_BASE + n * KW + kw) : '0;
    assign write_en_bar1 = (state == S_WRITE);
    assign data_in_bar1  = pack_buf;
    assign write_en_bar0 = 1'b0;
    assign data_in_bar0  = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cfg       <= '0;
            m         <= '0;
            n         <= '0;
            kw        <= '0;
            elem      <= '0;
            wr_word   <= '0;
            wait_cnt  <= 1'b0;
            last_elem <= 1'b0;
            acc       <= '0;
            pack_buf  <= '0;
            vld_pipe  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            vld_pipe <= {vld_pipe[STAGES-1:0], state == S_ISSUE};
            if (vld_pipe[STAGES])
                acc <= acc + dot;

            case (state)
                S_IDLE: if (start) begin
                    cfg      <= '{out_int8: cfg_out_int8, relu: cfg_relu, shift: cfg_shift};
                    m        <= '0;
                    n        <= '0;
                    kw       <= '0;
                    elem     <= '0;
                    wr_word  <= '0;
                    acc      <= '0;
                    pack_buf <= '0;
                    busy     <= 1'b1;
                    state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (kw == KW - 1) begin
                        kw       <= '0;
                        wait_cnt <= 1'b0;
                        state    <= S_WAIT;
                    end else begin
                        kw <= kw + 1;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= 1'b1;
                    if (wait_cnt)
                        state <= S_POST;
                end
                S_POST: begin
                    for (int j = 0; j < PACK8; j++)
                        if (cfg.out_int8 && slot == j)
                            pack_buf[j*OW_INT8 +: OW_INT8] <= r8;
                    for (int j = 0; j < PACK32; j++)
                        if (!cfg.out_int8 && slot == j)
                            pack_buf[j*OW_INT32 +: OW_INT32] <= 32'(r_shift);
                    acc  <= '0;
                    elem <= elem + 1;
                    if (n == N - 1) begin
                        n <= '0;
                        m <= m + 1;
                    end else begin
                        n <= n + 1;
                    end
                    if (last_slot) begin
                        last_elem <= is_last;
                        state     <= S_WRITE;
                    end else if (is_last) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_WRITE: begin
                    wr_word <= wr_word + 1;
                    if (last_elem) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
